// File: rtl/reg_file_sb.sv
// Register file with per-register pending-write counters for decode-stage stall tracking.
// Optional write-through forwarding on the read ports: define REG_FILE_BYPASS_EN.

module reg_file_sb_rd_port #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int CNT_W    = 2,
    parameter int NUM_REGS = 32
) (
    input  logic                               reset,
    input  logic [ADDR_W-1:0]                  addr,
    input  logic [NUM_REGS-1:0][DATA_W-1:0]    regs,
    input  logic [NUM_REGS-1:0][CNT_W-1:0]     cnt,
    input  logic                               fwd_en,
    input  logic [DATA_W-1:0]                  fwd_data,
    output logic [DATA_W-1:0]                  data,
    output logic                               busy
);
    logic [CNT_W-1:0] c;
    logic [CNT_W-1:0] c_eff;
    logic             dec;

    always_comb begin
        c     = cnt[addr];
        // A retire landing this cycle already counts as done for the reader.
        dec   = fwd_en && (c != '0);
        c_eff = c - CNT_W'(dec);
        data  = fwd_en ? fwd_data : regs[addr];
        busy  = (c_eff != '0);
        if (reset || addr == '0) begin
            data = '0;
            busy = 1'b0;
        end
    end
endmodule

module reg_file_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int CNT_W  = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       issue_en,
    input  logic [ADDR_W-1:0]          issue_addr,
    output logic                       issue_full,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       pending_any,
    output logic                       err_underflow
);
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [NUM_REGS-1:0][CNT_W-1:0]  cnt;
    logic [NUM_REGS-1:0]             inc_v;
    logic [NUM_REGS-1:0]             dec_v;
    logic                            err_q;
    logic                            any_nz;

    // A retire to the same register frees the slot the issue needs.
    assign issue_full = issue_en && (issue_addr != '0) && (cnt[issue_addr] == CNT_MAX)
                        && !(wr_en && (wr_addr == issue_addr));

    always_comb begin
        inc_v  = '0;
        dec_v  = '0;
        any_nz = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            inc_v[r] = issue_en && !issue_full && (issue_addr == ADDR_W'(r));
            dec_v[r] = wr_en && (wr_addr == ADDR_W'(r)) && (cnt[r] != '0);
            any_nz   = any_nz || (cnt[r] != '0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            regs  <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            if (wr_en && wr_addr != '0) begin
                regs[wr_addr] <= wr_data;
                if (cnt[wr_addr] == '0)
                    err_q <= 1'b1;
            end
            for (int r = 1; r < NUM_REGS; r++) begin
                if (inc_v[r] && !dec_v[r])
                    cnt[r] <= cnt[r] + 1'b1;
                else if (dec_v[r] && !inc_v[r])
                    cnt[r] <= cnt[r] - 1'b1;
            end
        end
    end

    assign pending_any   = any_nz && !reset;
    assign err_underflow = err_q && !reset;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic fwd;
`ifdef REG_FILE_BYPASS_EN
        assign fwd = wr_en && (wr_addr == rd_addr[i*ADDR_W +: ADDR_W]);
`else
        assign fwd = 1'b0;
`endif
        reg_file_sb_rd_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .CNT_W   (CNT_W),
            .NUM_REGS(NUM_REGS)
        ) u_rd (
            .reset   (reset),
            .addr    (rd_addr[i*ADDR_W +: ADDR_W]),
            .regs    (regs),
            .cnt     (cnt),
            .fwd_en  (fwd),
            .fwd_data(wr_data),
            .data    (rd_data[i*DATA_W +: DATA_W]),
            .busy    (rd_busy[i])
        );
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed + random traffic against an array/counter model,
// plus a 4-port 16-bit instance for slice checks.
module tb_reg_file_sb;
`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        issue_en, issue_full, wr_en, pending_any, err_underflow;
    logic [4:0]  issue_addr, wr_addr;
    logic [31:0] wr_data;

    logic        s_reset, s_issue_en, s_issue_full, s_wr_en, s_pending_any, s_err;
    logic [11:0] s_rd_addr;
    logic [63:0] s_rd_data;
    logic [3:0]  s_rd_busy;
    logic [2:0]  s_issue_addr, s_wr_addr;
    logic [15:0] s_wr_data;

    reg_file_sb dut (
        .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .issue_en(issue_en), .issue_addr(issue_addr),
        .issue_full(issue_full), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pending_any(pending_any), .err_underflow(err_underflow)
    );

    reg_file_sb #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .CNT_W(2)) dut_s (
        .clock(clock), .reset(s_reset), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
        .rd_busy(s_rd_busy), .issue_en(s_issue_en), .issue_addr(s_issue_addr),
        .issue_full(s_issue_full), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
        .pending_any(s_pending_any), .err_underflow(s_err)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] m_regs [32];
    int          m_cnt  [32];
    bit          m_err;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (reset || a == 0) return 32'h0;
        if (BYP && wr_en && wr_addr == a) return wr_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        int c;
        if (reset || a == 0) return 1'b0;
        c = m_cnt[a];
        if (BYP && wr_en && wr_addr == a && c > 0) c = c - 1;
        return c != 0;
    endfunction

    function automatic logic exp_full();
        return issue_en && issue_addr != 0 && m_cnt[issue_addr] == 3
               && !(wr_en && wr_addr == issue_addr);
    endfunction

    function automatic logic exp_pending();
        if (reset) return 1'b0;
        for (int r = 1; r < 32; r++) if (m_cnt[r] != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_update();
        bit acc, ret;
        if (reset) begin
            for (int r = 0; r < 32; r++) begin m_regs[r] = 0; m_cnt[r] = 0; end
            m_err = 0;
            return;
        end
        acc = issue_en && !exp_full() && issue_addr != 0;
        ret = wr_en && wr_addr != 0 && m_cnt[wr_addr] > 0;
        if (wr_en && wr_addr != 0) begin
            if (m_cnt[wr_addr] == 0) m_err = 1;
            m_regs[wr_addr] = wr_data;
        end
        if (ret) m_cnt[wr_addr] = m_cnt[wr_addr] - 1;
        if (acc) m_cnt[issue_addr] = m_cnt[issue_addr] + 1;
    endtask

    task automatic step(input string ph);
        @(negedge clock);
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("%s rd_data%0d", ph, p), 64'(rd_data[p*32 +: 32]), 64'(exp_rd(rd_addr[p*5 +: 5])));
            chk($sformatf("%s rd_busy%0d", ph, p), 64'(rd_busy[p]), 64'(exp_busy(rd_addr[p*5 +: 5])));
        end
        chk({ph, " issue_full"}, 64'(issue_full), 64'(exp_full()));
        chk({ph, " pending_any"}, 64'(pending_any), 64'(exp_pending()));
        chk({ph, " err_underflow"}, 64'(err_underflow), 64'(m_err && !reset));
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic drive(input logic ie, input logic [4:0] ia, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] r0, input logic [4:0] r1);
        issue_en = ie; issue_addr = ia; wr_en = we; wr_addr = wa; wr_data = wd;
        rd_addr = {r1, r0};
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin m_regs[r] = 0; m_cnt[r] = 0; end
        m_err = 0;
        reset = 1'b1; s_reset = 1'b1;
        s_issue_en = 0; s_issue_addr = 0; s_wr_en = 0; s_wr_addr = 0; s_wr_data = 0; s_rd_addr = 0;
        drive(0, 0, 0, 0, 0, 5, 0);
        step("reset"); step("reset");
        reset = 1'b0;

        drive(0, 0, 1, 5, 32'hDEADBEEF, 5, 0);  step("wr_r5");
        drive(0, 0, 0, 0, 0, 5, 5);             step("rd_r5");
        drive(0, 0, 1, 0, 32'h1234, 0, 5);      step("wr_r0");
        drive(0, 0, 0, 0, 0, 0, 0);             step("rd_r0");

        for (int k = 0; k < 3; k++) begin drive(1, 8, 0, 0, 0, 8, 0); step("issue_r8"); end
        drive(1, 8, 0, 0, 0, 8, 0);             step("issue_r8_full");
        drive(1, 8, 1, 8, 32'h88, 8, 0);        step("issue_r8_retire");
        for (int k = 0; k < 3; k++) begin drive(0, 0, 1, 8, 32'h80 + k, 8, 0); step("retire_r8"); end
        drive(0, 0, 0, 0, 0, 8, 8);             step("r8_idle");

        drive(1, 9, 0, 0, 0, 9, 0);             step("issue_r9");
        drive(0, 0, 1, 9, 32'hCAFEF00D, 9, 9);  step("wb_r9");
        drive(0, 0, 0, 0, 0, 9, 9);             step("r9_after");

        drive(0, 0, 1, 3, 32'h33, 3, 0);        step("underflow");
        drive(0, 0, 0, 0, 0, 3, 0);             step("err_held");
        step("err_held2");

        drive(1, 4, 0, 0, 0, 4, 6);             step("issue_r4");
        drive(1, 6, 0, 0, 0, 4, 6);             step("issue_r6");
        drive(0, 0, 1, 4, 7, 4, 6);             step("wb_r4");
        reset = 1'b1;
        drive(0, 0, 1, 6, 9, 4, 6);             step("reset_wb");
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 4, 6);             step("post_reset");

        for (int n = 0; n < 400; n++) begin
            logic [4:0] wa, ra0;
            wa  = 5'($urandom_range(0, 7));
            ra0 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 7));
            reset = ($urandom_range(0, 63) == 0);
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 2) == 0), wa, $urandom,
                  ra0, 5'($urandom_range(0, 31)));
            step("rand");
        end
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);

        @(posedge clock); #1;
        s_reset = 1'b0;
        s_wr_en = 1; s_wr_addr = 1; s_wr_data = 16'h0011; @(posedge clock); #1;
        s_wr_addr = 2; s_wr_data = 16'h0022;               @(posedge clock); #1;
        s_wr_addr = 7; s_wr_data = 16'h0077;               @(posedge clock); #1;
        s_wr_en = 0;
        s_rd_addr = {3'd7, 3'd1, 3'd2, 3'd1};
        @(negedge clock);
        chk("s rd_data0", 64'(s_rd_data[15:0]),  64'h0011);
        chk("s rd_data1", 64'(s_rd_data[31:16]), 64'h0022);
        chk("s rd_data2", 64'(s_rd_data[47:32]), 64'h0011);
        chk("s rd_data3", 64'(s_rd_data[63:48]), 64'h0077);
        chk("s rd_busy",  64'(s_rd_busy), 64'h0);
        chk("s err",      64'(s_err), 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file with a per-register pending-write scoreboard for the MIPS decode stage. Holds NUM_REGS = 2^ADDR_W registers of DATA_W bits with NUM_RD read ports. Decode uses the read ports for rs/rt operands, registers outstanding destination writes through the issue port, and retires them through the write-back port. Per-register busy flags drive the decode stall logic.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; NUM_REGS = 2^ADDR_W
- NUM_RD, 2, number of read ports
- CNT_W, 2, width of each pending-write counter; maximum outstanding writes per register = 2^CNT_W-1

Ports:
- clock  in  1  single clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- rd_addr  in  NUM_RD*ADDR_W  read indices; port i uses slice i
- rd_data  out  NUM_RD*DATA_W  read data, combinational from rd_addr
- rd_busy  out  NUM_RD  port i target has a write pending
- issue_en  in  1  register one pending write to issue_addr
- issue_addr  in  ADDR_W  destination register of the issued instruction
- issue_full  out  1  issue_addr counter is saturated, so the issue is refused
- wr_en  in  1  write-back strobe
- wr_addr  in  ADDR_W  write-back register
- wr_data  in  DATA_W  write-back data
- pending_any  out  1  some counter is nonzero
- err_underflow  out  1  sticky flag: a write-back occurred with the counter at 0

## Operation
- Register 0 always reads 0. Writes, issues and busy tracking for index 0 are ignored: rd_busy=0, and issue_full is never asserted for addr 0.
- Write-back: on posedge with wr_en and wr_addr≠0, regs[wr_addr]←wr_data.
- Per-register counter cnt[r] counts outstanding writes.
- Counter update at each posedge:
  - inc = issue_en & ~issue_full & addr match; dec = wr_en & addr match & cnt≠0.
  - inc&dec leaves cnt unchanged. inc alone adds 1. dec alone subtracts 1.
- issue_full = issue_en & (cnt[issue_addr]==max) & ~(wr_en & wr_addr==issue_addr). A simultaneous retire to the same register frees a slot, so the issue is accepted and cnt is unchanged.
- A refused issue leaves no state change. Decode must hold the instruction and retry.
- Write-back with cnt[wr_addr]==0 still writes data, leaves cnt at 0 and sets err_underflow. err_underflow clears only on reset.
- Default rd_busy[i] = cnt[rd_addr_i]≠0.
- pending_any = OR of all cnt≠0, using registered state only.
- Reset: all regs←0, all cnt←0, err_underflow←0. Reset dominates wr_en and issue_en in the same cycle.
- Output values during and after reset: rd_data=0, rd_busy=0, issue_full=0 when issue_en=0, pending_any=0, err_underflow=0.

## Timing
- Read path is combinational: addr→data in the same cycle.
- Without bypass, a write on edge N is visible on reads starting in cycle N+1.
- Issue on edge N: rd_busy on that register rises in cycle N+1.
- Final retire (cnt 1→0) on edge N: rd_busy falls in cycle N+1, or in cycle N with bypass.
- issue_full is combinational from issue_en/issue_addr/wr_en/wr_addr and current cnt. There is no extra latency.
- Counter arithmetic is modulo-free: saturation is prevented by issue_full, and underflow by the cnt≠0 guard.

## Configuration
- REG_FILE_BYPASS_EN defined (write-through forwarding):
  - if wr_en & wr_addr==rd_addr_i & addr≠0, then rd_data_i=wr_data in the same cycle;
  - rd_busy_i = (cnt − dec_match)≠0, so a final retire unblocks a dependent read in the same cycle.
- REG_FILE_BYPASS_EN undefined: reads return the array contents only, and rd_busy uses registered cnt only. Decode sees one extra stall cycle per dependency.

## Test plan
- Reset, then write 0xDEADBEEF to r5. Read r5 next cycle → 0xDEADBEEF. Write 0x1234 to r0 → r0 still reads 0, rd_busy 0.
- Issue r8 three times with CNT_W=2 → cnt 3. Fourth issue → issue_full=1, cnt stays 3. Fourth issue plus simultaneous wr r8 → accepted, cnt 3. Three more retires → rd_busy 0, pending_any 0.
- Bypass on: issue r9, then wr r9=0xCAFEF00D with port0 reading r9 → same cycle rd_data0=0xCAFEF00D, rd_busy0=0. Bypass off: same stimulus → old value and busy=1 that cycle, new value and busy=0 next cycle.
- Write-back to r3 with cnt 0 → data written, err_underflow=1 and held until reset.
- Issue r4, r6 and write r4=7, then assert reset together with wr r6=9 → next cycle all regs 0, all busy 0, pending_any 0, err 0.
- NUM_RD=4, DATA_W=16, ADDR_W=3: four ports read r1,r2,r1,r7 after writes 0x0011/0x0022/0x0077 → each port returns the correct slice, r7 index max is handled.
